// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the MEM stage load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_MISAL   = 2'b01,
    CAUSE_BUSERR  = 2'b10,
    CAUSE_TIMEOUT = 2'b11
  } lsu_cause_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - size legality, misalignment detect, store lane shift, load extract/extend
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NB     = DATA_W / 8,
  parameter int OFF_W  = $clog2(NB)
) (
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        funct3,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] st_data,
  output logic              bad,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata,
  input  logic [2:0]        ld_funct3,
  input  logic [OFF_W-1:0]  ld_off,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ld_data
);

  localparam bit IS64 = (DATA_W == 64);

  logic [1:0]        size;
  logic              illegal;
  logic              misal;
  logic [NB-1:0]     base;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] mask;
  logic              sbit;

  assign size = funct3[1:0];

  // A load wins when both rd and wr are set, matching the write-enable decode in the top.
  always_comb begin
    illegal = 1'b0;
    if (mem_rd) begin
      illegal = (funct3 == 3'b111) || (!IS64 && (funct3 == F3_D || funct3 == F3_WU));
    end else if (mem_wr) begin
      illegal = funct3[2] || (!IS64 && size == SZ_D);
    end
  end

  always_comb begin
    misal = 1'b0;
    case (size)
      SZ_H:    misal = off[0];
      SZ_W:    misal = |off[1:0];
      SZ_D:    misal = |off;
      default: misal = 1'b0;
    endcase
  end

  assign bad = (mem_rd | mem_wr) & (illegal | misal);

  always_comb begin
    base = '0;
    case (size)
      SZ_B:    base = NB'(8'h01);
      SZ_H:    base = NB'(8'h03);
      SZ_W:    base = NB'(8'h0F);
      default: base = NB'(8'hFF);
    endcase
  end

  assign be    = base << off;
  assign wdata = st_data << {off, 3'b000};

  assign sh = rdata >> {ld_off, 3'b000};

  always_comb begin
    mask = '1;
    sbit = 1'b0;
    case (ld_funct3[1:0])
      SZ_B:    begin mask = DATA_W'(8'hFF);         sbit = sh[7];  end
      SZ_H:    begin mask = DATA_W'(16'hFFFF);      sbit = sh[15]; end
      SZ_W:    begin mask = DATA_W'(32'hFFFF_FFFF); sbit = sh[31]; end
      default: begin mask = '1;                     sbit = 1'b0;   end
    endcase
    ld_data = (sh & mask) | ({DATA_W{sbit & ~ld_funct3[2]}} & ~mask);
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM stage: bus FSM, timeout counter, hold and write-back registers
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                i_ex_valid,
  input  logic                i_ex_mem_to_reg,
  input  logic                i_ex_rw_sel,
  input  logic                i_ex_reg_wr,
  input  logic                i_ex_mem_rd,
  input  logic                i_ex_mem_wr,
  input  logic [ADDR_W-1:0]   i_ex_pc_plus_4,
  input  logic [ADDR_W-1:0]   i_ex_alu_result,
  input  logic [DATA_W-1:0]   i_ex_reg_read_data2,
  input  logic [4:0]          i_ex_reg_dest,
  input  logic [2:0]          i_ex_funct3,
  output logic                o_stall,
  output logic                o_mem_req,
  input  logic                i_mem_gnt,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W/8-1:0] o_mem_be,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  input  logic                i_mem_err,
  output logic                o_ma_valid,
  output logic                o_ma_mem_to_reg,
  output logic                o_ma_rw_sel,
  output logic                o_ma_reg_wr,
  output logic [ADDR_W-1:0]   o_ma_pc_plus_4,
  output logic [ADDR_W-1:0]   o_ma_result,
  output logic [DATA_W-1:0]   o_ma_read_data,
  output logic [4:0]          o_ma_reg_dest,
  output logic [1:0]          o_ma_cause
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  lsu_state_e        state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic              accept, is_mem, is_st, bad, timed_out;
  logic              go_req, wb_ex, resp_fire, wb_hold, wb_c;
  logic [NB-1:0]     be_c;
  logic [DATA_W-1:0] wdata_c, ld_data;
  lsu_cause_e        resp_cause, h_cause, c_cause;
  logic [DATA_W-1:0] resp_data, h_rdata, c_data;

  logic              h_mem_to_reg, h_rw_sel, h_reg_wr, h_ld;
  logic [ADDR_W-1:0] h_pc4, h_result;
  logic [4:0]        h_dest;
  logic [2:0]        h_funct3;
  logic [OFF_W-1:0]  h_off;

  assign o_stall   = (state != S_IDLE);
  assign o_mem_req = (state == S_REQ);
  assign accept    = clk_en & i_ex_valid & ~o_stall;
  assign is_mem    = i_ex_mem_rd | i_ex_mem_wr;
  assign is_st     = i_ex_mem_wr & ~i_ex_mem_rd;
  // Fires on the cycle whose edge would bring the counter to TIMEOUT_CYC.
  assign timed_out = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .mem_rd    (i_ex_mem_rd),
    .mem_wr    (i_ex_mem_wr),
    .funct3    (i_ex_funct3),
    .off       (i_ex_alu_result[OFF_W-1:0]),
    .st_data   (i_ex_reg_read_data2),
    .bad       (bad),
    .be        (be_c),
    .wdata     (wdata_c),
    .ld_funct3 (h_funct3),
    .ld_off    (h_off),
    .rdata     (i_mem_rdata),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_n    = state;
    go_req     = 1'b0;
    wb_ex      = 1'b0;
    resp_fire  = 1'b0;
    wb_hold    = 1'b0;
    resp_cause = CAUSE_NONE;
    resp_data  = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_mem && !bad) begin
            go_req  = 1'b1;
            state_n = S_REQ;
          end else begin
            wb_ex = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (timed_out) begin
          resp_fire  = 1'b1;
          resp_cause = CAUSE_TIMEOUT;
        end else if (i_mem_gnt) begin
          state_n = S_RESP;
        end
      end
      S_RESP: begin
        if (i_mem_rvalid) begin
          resp_fire = 1'b1;
          if (i_mem_err) begin
            resp_cause = CAUSE_BUSERR;
          end else if (h_ld) begin
            resp_data = ld_data;
          end
        end else if (timed_out) begin
          resp_fire  = 1'b1;
          resp_cause = CAUSE_TIMEOUT;
        end
      end
      S_DONE: begin
        if (clk_en) begin
          wb_hold = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (resp_fire) state_n = clk_en ? S_IDLE : S_DONE;
  end

  assign wb_c = (resp_fire & clk_en) | wb_hold;

  always_comb begin
    c_cause = resp_cause;
    c_data  = resp_data;
    if (wb_hold) begin
      c_cause = h_cause;
      c_data  = h_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (accept) cnt <= '0;
      else if (state == S_REQ || state == S_RESP) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_be     <= '0;
      o_mem_wdata  <= '0;
      h_mem_to_reg <= 1'b0;
      h_rw_sel     <= 1'b0;
      h_reg_wr     <= 1'b0;
      h_ld         <= 1'b0;
      h_pc4        <= '0;
      h_result     <= '0;
      h_dest       <= '0;
      h_funct3     <= '0;
      h_off        <= '0;
      h_cause      <= CAUSE_NONE;
      h_rdata      <= '0;
    end else begin
      if (go_req) begin
        o_mem_we     <= is_st;
        o_mem_addr   <= {i_ex_alu_result[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        o_mem_be     <= be_c;
        o_mem_wdata  <= is_st ? wdata_c : '0;
        h_mem_to_reg <= i_ex_mem_to_reg;
        h_rw_sel     <= i_ex_rw_sel;
        h_reg_wr     <= i_ex_reg_wr;
        h_ld         <= ~is_st;
        h_pc4        <= i_ex_pc_plus_4;
        h_result     <= i_ex_alu_result;
        h_dest       <= i_ex_reg_dest;
        h_funct3     <= i_ex_funct3;
        h_off        <= i_ex_alu_result[OFF_W-1:0];
      end
      if (resp_fire) begin
        h_cause <= resp_cause;
        h_rdata <= resp_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ma_valid      <= 1'b0;
      o_ma_mem_to_reg <= 1'b0;
      o_ma_rw_sel     <= 1'b0;
      o_ma_reg_wr     <= 1'b0;
      o_ma_pc_plus_4  <= '0;
      o_ma_result     <= '0;
      o_ma_read_data  <= '0;
      o_ma_reg_dest   <= '0;
      o_ma_cause      <= CAUSE_NONE;
    end else begin
      o_ma_valid <= wb_ex | wb_c;
      if (wb_ex) begin
        o_ma_mem_to_reg <= i_ex_mem_to_reg;
        o_ma_rw_sel     <= i_ex_rw_sel;
        o_ma_reg_wr     <= i_ex_reg_wr & ~bad;
        o_ma_pc_plus_4  <= i_ex_pc_plus_4;
        o_ma_result     <= i_ex_alu_result;
        o_ma_read_data  <= '0;
        o_ma_reg_dest   <= i_ex_reg_dest;
        o_ma_cause      <= bad ? CAUSE_MISAL : CAUSE_NONE;
      end else if (wb_c) begin
        o_ma_mem_to_reg <= h_mem_to_reg;
        o_ma_rw_sel     <= h_rw_sel;
        o_ma_reg_wr     <= h_reg_wr & (c_cause == CAUSE_NONE);
        o_ma_pc_plus_4  <= h_pc4;
        o_ma_result     <= h_result;
        o_ma_read_data  <= c_data;
        o_ma_reg_dest   <= h_dest;
        o_ma_cause      <= c_cause;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed bench for a 32-bit and a 64-bit (short timeout) MEM stage
module tb_mem_stage_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        ex_mem_to_reg = 0, ex_rw_sel = 0, ex_reg_wr = 0, ex_mem_rd = 0, ex_mem_wr = 0;
  logic [31:0] ex_pc_plus_4 = 0, ex_alu_result = 0;
  logic [63:0] ex_data2 = 0;
  logic [4:0]  ex_reg_dest = 0;
  logic [2:0]  ex_funct3 = 0;

  logic        a_rst = 1, a_clk_en = 1, a_ex_valid = 0, a_gnt = 0, a_rvalid = 0, a_err = 0;
  logic [31:0] a_rdata = 0;
  logic        a_stall, a_req, a_we, a_ma_valid, a_ma_mem_to_reg, a_ma_rw_sel, a_ma_reg_wr;
  logic [31:0] a_addr, a_wdata, a_ma_pc4, a_ma_result, a_ma_read_data;
  logic [3:0]  a_be;
  logic [4:0]  a_ma_dest;
  logic [1:0]  a_ma_cause;

  logic        b_rst = 1, b_clk_en = 1, b_ex_valid = 0, b_gnt = 0, b_rvalid = 0, b_err = 0;
  logic [63:0] b_rdata = 0;
  logic        b_stall, b_req, b_we, b_ma_valid, b_ma_mem_to_reg, b_ma_rw_sel, b_ma_reg_wr;
  logic [31:0] b_addr, b_ma_pc4, b_ma_result;
  logic [63:0] b_wdata, b_ma_read_data;
  logic [7:0]  b_be;
  logic [4:0]  b_ma_dest;
  logic [1:0]  b_ma_cause;

  mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(255)) u_a (
    .clk(clk), .rst(a_rst), .clk_en(a_clk_en), .i_ex_valid(a_ex_valid),
    .i_ex_mem_to_reg(ex_mem_to_reg), .i_ex_rw_sel(ex_rw_sel), .i_ex_reg_wr(ex_reg_wr),
    .i_ex_mem_rd(ex_mem_rd), .i_ex_mem_wr(ex_mem_wr), .i_ex_pc_plus_4(ex_pc_plus_4),
    .i_ex_alu_result(ex_alu_result), .i_ex_reg_read_data2(ex_data2[31:0]),
    .i_ex_reg_dest(ex_reg_dest), .i_ex_funct3(ex_funct3),
    .o_stall(a_stall), .o_mem_req(a_req), .i_mem_gnt(a_gnt), .o_mem_we(a_we),
    .o_mem_addr(a_addr), .o_mem_be(a_be), .o_mem_wdata(a_wdata),
    .i_mem_rvalid(a_rvalid), .i_mem_rdata(a_rdata), .i_mem_err(a_err),
    .o_ma_valid(a_ma_valid), .o_ma_mem_to_reg(a_ma_mem_to_reg), .o_ma_rw_sel(a_ma_rw_sel),
    .o_ma_reg_wr(a_ma_reg_wr), .o_ma_pc_plus_4(a_ma_pc4), .o_ma_result(a_ma_result),
    .o_ma_read_data(a_ma_read_data), .o_ma_reg_dest(a_ma_dest), .o_ma_cause(a_ma_cause)
  );

  mem_stage_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYC(4)) u_b (
    .clk(clk), .rst(b_rst), .clk_en(b_clk_en), .i_ex_valid(b_ex_valid),
    .i_ex_mem_to_reg(ex_mem_to_reg), .i_ex_rw_sel(ex_rw_sel), .i_ex_reg_wr(ex_reg_wr),
    .i_ex_mem_rd(ex_mem_rd), .i_ex_mem_wr(ex_mem_wr), .i_ex_pc_plus_4(ex_pc_plus_4),
    .i_ex_alu_result(ex_alu_result), .i_ex_reg_read_data2(ex_data2),
    .i_ex_reg_dest(ex_reg_dest), .i_ex_funct3(ex_funct3),
    .o_stall(b_stall), .o_mem_req(b_req), .i_mem_gnt(b_gnt), .o_mem_we(b_we),
    .o_mem_addr(b_addr), .o_mem_be(b_be), .o_mem_wdata(b_wdata),
    .i_mem_rvalid(b_rvalid), .i_mem_rdata(b_rdata), .i_mem_err(b_err),
    .o_ma_valid(b_ma_valid), .o_ma_mem_to_reg(b_ma_mem_to_reg), .o_ma_rw_sel(b_ma_rw_sel),
    .o_ma_reg_wr(b_ma_reg_wr), .o_ma_pc_plus_4(b_ma_pc4), .o_ma_result(b_ma_result),
    .o_ma_read_data(b_ma_read_data), .o_ma_reg_dest(b_ma_dest), .o_ma_cause(b_ma_cause)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_ex(input logic rd, input logic wr, input logic rwr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [63:0] d2);
    ex_mem_rd     = rd;
    ex_mem_wr     = wr;
    ex_reg_wr     = rwr;
    ex_mem_to_reg = rd;
    ex_rw_sel     = ~rd;
    ex_funct3     = f3;
    ex_alu_result = addr;
    ex_pc_plus_4  = addr + 32'd4;
    ex_reg_dest   = 5'd7;
    ex_data2      = d2;
  endtask

  // Accepts one op on instance A and plays a bus that grants after gdly waits and answers next cycle.
  task automatic a_op(input logic [31:0] rdat, input int gdly, input logic e,
                      output int lat, output int stall_n, output logic req_seen,
                      output logic cwe, output logic [31:0] caddr, output logic [3:0] cbe,
                      output logic [31:0] cwdata);
    int g;
    int phase;
    lat = 1; stall_n = 0; req_seen = 0; g = 0; phase = 0;
    cwe = 0; caddr = 0; cbe = 0; cwdata = 0;
    a_ex_valid = 1;
    @(negedge clk);
    a_ex_valid = 0;
    while (!a_ma_valid && lat < 40) begin
      if (a_stall) stall_n++;
      a_gnt = 0; a_rvalid = 0; a_err = 0;
      if (phase == 0 && a_req) begin
        if (!req_seen) begin
          req_seen = 1; cwe = a_we; caddr = a_addr; cbe = a_be; cwdata = a_wdata;
        end
        if (g == gdly) begin a_gnt = 1; phase = 1; end
        else g++;
      end else if (phase == 1) begin
        a_rvalid = 1; a_rdata = rdat; a_err = e; phase = 2;
      end
      @(negedge clk);
      lat++;
    end
    a_gnt = 0; a_rvalid = 0; a_err = 0;
    check("a_valid_seen", a_ma_valid, 1);
  endtask

  task automatic a_drop();
    @(negedge clk);
    check("a_valid_one_cycle", a_ma_valid, 0);
  endtask

  initial begin
    int lat, sn, n, reqs, pulses;
    logic rs, cwe;
    logic [31:0] caddr, cwd;
    logic [3:0] cbe;

    @(negedge clk);
    @(negedge clk);
    check("rst_a_stall", a_stall, 0);
    check("rst_a_bus", {a_req, a_we, a_be, a_addr, a_wdata}, 0);
    check("rst_a_wb", {a_ma_valid, a_ma_reg_wr, a_ma_cause, a_ma_read_data, a_ma_result}, 0);
    check("rst_b_bus", {b_req, b_stall, b_we, b_be, b_addr}, 0);
    check("rst_b_wb", {b_ma_valid, b_ma_cause, b_ma_read_data}, 0);
    a_rst = 0;
    b_rst = 0;
    @(negedge clk);

    set_ex(0, 1, 0, 3'b000, 32'h103, 64'hA5);
    a_op(0, 0, 0, lat, sn, rs, cwe, caddr, cbe, cwd);
    check("sb_addr", caddr, 32'h100);
    check("sb_be", cbe, 4'b1000);
    check("sb_wdata", cwd, 32'hA500_0000);
    check("sb_we", cwe, 1);
    check("sb_lat", lat, 3);
    check("sb_reg_wr", a_ma_reg_wr, 0);
    check("sb_cause", a_ma_cause, 0);
    a_drop();

    set_ex(1, 0, 1, 3'b001, 32'h202, 0);
    a_op(32'h8001_1234, 2, 0, lat, sn, rs, cwe, caddr, cbe, cwd);
    check("lh_data", a_ma_read_data, 32'hFFFF_8001);
    check("lh_stall_cycles", sn, 4);
    check("lh_lat", lat, 5);
    check("lh_be", cbe, 4'b1100);
    check("lh_reg_wr", a_ma_reg_wr, 1);
    a_drop();

    set_ex(1, 0, 1, 3'b101, 32'h202, 0);
    a_op(32'h8001_1234, 2, 0, lat, sn, rs, cwe, caddr, cbe, cwd);
    check("lhu_data", a_ma_read_data, 32'h0000_8001);
    check("lhu_stall_cycles", sn, 4);
    a_drop();

    set_ex(1, 0, 1, 3'b010, 32'h301, 0);
    a_op(0, 0, 0, lat, sn, rs, cwe, caddr, cbe, cwd);
    check("lw_mis_noreq", rs, 0);
    check("lw_mis_lat", lat, 1);
    check("lw_mis_cause", a_ma_cause, 2'b01);
    check("lw_mis_reg_wr", a_ma_reg_wr, 0);
    a_drop();

    set_ex(1, 0, 1, 3'b011, 32'h300, 0);
    a_op(0, 0, 0, lat, sn, rs, cwe, caddr, cbe, cwd);
    check("ld32_noreq", rs, 0);
    check("ld32_cause", a_ma_cause, 2'b01);
    a_drop();

    set_ex(1, 0, 1, 3'b010, 32'h400, 0);
    a_op(32'h1234_5678, 0, 1, lat, sn, rs, cwe, caddr, cbe, cwd);
    check("lw_err_cause", a_ma_cause, 2'b10);
    check("lw_err_reg_wr", a_ma_reg_wr, 0);
    check("lw_err_data", a_ma_read_data, 0);
    a_drop();

    set_ex(0, 0, 1, 3'b000, 32'h1234, 0);
    a_op(0, 0, 0, lat, sn, rs, cwe, caddr, cbe, cwd);
    check("alu_lat", lat, 1);
    check("alu_noreq", rs, 0);
    check("alu_fields", {a_ma_result, a_ma_pc4, a_ma_reg_wr, a_ma_rw_sel, a_ma_cause, a_ma_dest},
          {32'h1234, 32'h1238, 1'b1, 1'b1, 2'b00, 5'd7});
    check("alu_data", a_ma_read_data, 0);
    a_drop();

    set_ex(1, 0, 1, 3'b010, 32'h500, 0);
    a_ex_valid = 1;
    @(negedge clk);
    a_ex_valid = 0;
    check("ce_req", a_req, 1);
    a_gnt = 1;
    @(negedge clk);
    a_gnt = 0; a_clk_en = 0; a_rvalid = 1; a_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    a_rvalid = 0;
    check("ce_done_stall", a_stall, 1);
    check("ce_no_wb", {a_ma_valid, a_ma_read_data}, 0);
    @(negedge clk);
    check("ce_still_held", {a_stall, a_ma_valid}, 2'b10);
    a_clk_en = 1;
    @(negedge clk);
    check("ce_valid", a_ma_valid, 1);
    check("ce_data", a_ma_read_data, 32'hDEAD_BEEF);
    check("ce_stall_clear", a_stall, 0);
    a_drop();

    set_ex(1, 0, 1, 3'b011, 32'h1008, 0);
    b_ex_valid = 1;
    @(negedge clk);
    b_ex_valid = 0;
    check("ld64_req", {b_req, b_we}, 2'b10);
    check("ld64_addr", b_addr, 32'h1008);
    check("ld64_be", b_be, 8'hFF);
    b_gnt = 1;
    @(negedge clk);
    b_gnt = 0; b_rvalid = 1; b_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    b_rvalid = 0;
    check("ld64_valid", b_ma_valid, 1);
    check("ld64_data", b_ma_read_data, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);

    set_ex(1, 0, 1, 3'b010, 32'h2000, 0);
    b_ex_valid = 1;
    @(negedge clk);
    b_ex_valid = 0;
    n = 0; reqs = 0;
    while (!b_ma_valid && n < 20) begin
      if (b_req) reqs++;
      @(negedge clk);
      n++;
    end
    check("to_req_cycles", reqs, 4);
    check("to_valid", b_ma_valid, 1);
    check("to_cause", b_ma_cause, 2'b11);
    check("to_reg_wr", b_ma_reg_wr, 0);
    check("to_req_low", b_req, 0);
    @(negedge clk);
    b_rvalid = 1;
    @(negedge clk);
    b_rvalid = 0;
    check("to_late_rvalid", {b_ma_valid, b_stall}, 0);

    set_ex(1, 0, 1, 3'b010, 32'h3000, 0);
    b_ex_valid = 1;
    @(negedge clk);
    b_ex_valid = 0;
    check("rst_mid_req_pre", b_req, 1);
    b_rst = 1;
    #1;
    check("rst_mid_req_async", {b_req, b_stall}, 0);
    check("rst_mid_wb_clear", b_ma_cause, 0);
    @(negedge clk);
    b_rst = 0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (b_ma_valid) pulses++;
    end
    check("rst_mid_no_valid", pulses, 0);
    check("rst_mid_idle", b_stall, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Parametrised Memory Access stage for the RISC-V pipeline, sitting between Execute and Write Back. Generalises the MEM stage with a configurable data width (32/64), a request/grant/response data bus with wait states, byte-lane alignment for loads and stores, and fault reporting for misalignment, bus errors and timeouts. The stage stalls the upstream pipeline while a memory transaction is outstanding.

## Interface
- DATA_W, 32, data path width; 32 or 64. Defines NB = DATA_W/8 and OFF_W = log2(NB).
- ADDR_W, 32, address and PC width.
- TIMEOUT_CYC, 255, cycles from request to fault; 0 disables the timeout.

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- clk_en  in  1  accept and WB-register update enable
- i_ex_valid  in  1  EX holds a valid instruction
- i_ex_mem_to_reg, i_ex_rw_sel, i_ex_reg_wr, i_ex_mem_rd, i_ex_mem_wr  in  1 each  EX control
- i_ex_pc_plus_4  in  ADDR_W  PC+4
- i_ex_alu_result  in  ADDR_W  effective address or ALU result
- i_ex_reg_read_data2  in  DATA_W  store data
- i_ex_reg_dest  in  5  destination register
- i_ex_funct3  in  3  access size and sign
- o_stall  out  1  stage busy; upstream holds EX
- o_mem_req  out  1  bus request
- i_mem_gnt  in  1  request accepted
- o_mem_we  out  1  write when high
- o_mem_addr  out  ADDR_W  address with low OFF_W bits cleared
- o_mem_be  out  NB  byte enables
- o_mem_wdata  out  DATA_W  lane-shifted store data
- i_mem_rvalid  in  1  response valid (loads and stores)
- i_mem_rdata  in  DATA_W  read data
- i_mem_err  in  1  bus error, qualified by rvalid
- o_ma_valid  out  1  WB outputs valid for one cycle
- o_ma_mem_to_reg, o_ma_rw_sel, o_ma_reg_wr  out  1 each  forwarded control; reg_wr forced 0 on fault
- o_ma_pc_plus_4, o_ma_result  out  ADDR_W  forwarded values
- o_ma_read_data  out  DATA_W  aligned and extended load data
- o_ma_reg_dest  out  5  forwarded destination
- o_ma_cause  out  2  00 none, 01 misaligned or illegal size, 10 bus error, 11 timeout

## Operation
- FSM states: IDLE, REQ, RESP and DONE.
- IDLE, accept condition is clk_en & i_ex_valid & !o_stall:
  - Non-memory op: WB registers load at the edge; o_ma_valid=1 in the next cycle.
  - Misaligned or illegal op: no bus request; one-cycle completion with cause 01.
  - Aligned memory op: capture all EX fields plus bus fields, then go to REQ.
- REQ: o_mem_req=1 and the bus fields are held stable. On i_mem_gnt, go to RESP.
- RESP: on i_mem_rvalid, capture rdata and err. If clk_en=1, update WB and go to IDLE; otherwise go to DONE.
- DONE: wait for clk_en, then update WB and go to IDLE.
- The FSM advances in REQ/RESP regardless of clk_en. Only acceptance and WB updates are gated by clk_en.
- o_stall = (state != IDLE).
- Size decode: 000 LB, 100 LBU, 001 LH, 101 LHU, 010 LW, 110 LWU, 011 LD.
  - When DATA_W=32: 110 and 011 are illegal (cause 01); 111 is always illegal.
  - Stores accept only 000, 001, 010 and 011; 011 only when DATA_W=64.
- off = addr[OFF_W-1:0]. Misaligned when: half and off[0]≠0; word and off[1:0]≠0; dword and off≠0.
- Store lanes: be = {1,3,F,FF}[size] << off; wdata = data2 << 8*off.
- Load: rdata >> 8*off, then sign- or zero-extend to DATA_W per funct3.
- Timeout: the counter clears on accept and increments in REQ/RESP. When it reaches TIMEOUT_CYC:
  - drop the request;
  - complete with cause 11 via the RESP completion path, going to DONE when clk_en=0;
  - ignore any later rvalid.
- Bus error: cause 10; o_ma_read_data=0.

## Timing
- Reset: state IDLE, counter 0. Every o_ma_* output is 0, o_mem_req=0, o_stall=0. The bus fields o_mem_we, o_mem_addr, o_mem_be and o_mem_wdata are also 0.
- Reset mid-transaction clears o_mem_req immediately (async). No completion is reported.
- Non-memory, misaligned and illegal ops: latency 1 (accept edge → o_ma_valid).
- Memory op with zero wait states: accept at cycle 0, req in cycle 1 with gnt, rvalid in cycle 2, o_ma_valid in cycle 3.
  - Each gnt wait cycle adds 1; each rvalid wait cycle adds 1.
- i_mem_rvalid is ignored in IDLE and REQ. The bus guarantees at least one cycle between gnt and rvalid.
- o_ma_valid is high for exactly one cycle per completion.
- All WB outputs hold their value between completions.
- Bus outputs are registered, with no combinational path from EX inputs.

## Structure
- Shared package lsu_pkg holds:
  - the state enum;
  - funct3 size constants;
  - the cause enum (CAUSE_NONE, CAUSE_MISAL, CAUSE_BUSERR, CAUSE_TIMEOUT).
- Combinational sub-module lsu_align, parametrised by DATA_W, provides:
  - misalign/illegal detect;
  - store be/wdata generation;
  - load extract/extend.
- The top level holds the FSM, timeout counter, hold registers and WB registers.

## Test plan
- DATA_W=32, SB at addr 0x103, data2 0x000000A5, gnt and rvalid immediate → o_mem_addr 0x100, be 1000, wdata 0xA5000000, o_ma_valid in cycle 3, reg_wr 0.
- LH at 0x202, rdata 0x8001xxxx, gnt delayed 2 cycles → o_ma_read_data 0xFFFF8001; o_stall high for exactly 4 cycles. Repeat as LHU → 0x00008001.
- LW at 0x301 → no o_mem_req, o_ma_cause 01, reg_wr 0, valid 1 cycle after accept. LD with DATA_W=32 → cause 01.
- LW with rvalid+err → cause 10, reg_wr 0. Separately, TIMEOUT_CYC=4 with gnt never asserted → req drops after 4 cycles, cause 11.
- clk_en low while in RESP, rvalid arrives → state DONE, no WB update. clk_en rises → o_ma_valid with the correct data.
- DATA_W=64, LD at 0x1008, rdata 0x0123456789ABCDEF → exact value. Assert rst during REQ → o_mem_req low immediately, o_ma_valid never pulses.
